// File: rtl/gpio_port.sv
// Bidirectional WIDTH-pin GPIO port on the 8-bit peripheral bus with atomic set/clear
// writes, an input synchroniser and per-pin rising/falling edge interrupts.
module gpio_port #(
   parameter int         WIDTH       = 8,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] RST_OUT     = 8'h00,
   parameter logic [7:0] RST_DIR     = 8'h00
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       AD,
   input  logic [7:0]       DI,
   output logic [7:0]       DO,
   input  logic             rw,
   input  logic             cs,
   inout  wire  [WIDTH-1:0] gpio,
   output logic             irq
);

   localparam logic [7:0] ID_VAL = {3'(WIDTH - 1), 1'(SYNC_STAGES - 2), 4'b1010};

   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [WIDTH-1:0] rise_en_q, rise_en_d;
   logic [WIDTH-1:0] fall_en_q, fall_en_d;
   logic [WIDTH-1:0] status_q, status_d;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0] prev_q, prev_d;

   logic             we;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] w1c;
   logic [WIDTH-1:0] sync_last;
   logic [WIDTH-1:0] edge_set;
   logic [WIDTH-1:0] din;

   // Unimplemented register bits above WIDTH read back as 1.
   function automatic logic [7:0] widen(input logic [WIDTH-1:0] v);
      logic [7:0] r;
      r = 8'hFF;
      r[WIDTH-1:0] = v;
      return r;
   endfunction

   always_comb begin
      we        = cs & ~rw;
      wdata     = DI[WIDTH-1:0];
      sync_last = sync_q[SYNC_STAGES-1];

      sync_d[0] = gpio;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
      prev_d = sync_last;

      edge_set = (sync_last & ~prev_q & rise_en_q) | (~sync_last & prev_q & fall_en_q);

      out_d     = out_q;
      dir_d     = dir_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      w1c       = '0;
      if (we) begin
         case (AD)
            3'd0:    out_d     = wdata;
            3'd1:    dir_d     = wdata;
            3'd2:    out_d     = out_q | wdata;
            3'd3:    out_d     = out_q & ~wdata;
            3'd4:    rise_en_d = wdata;
            3'd5:    fall_en_d = wdata;
            3'd6:    w1c       = wdata;
            default: ;
         endcase
      end
      // A new edge in the same cycle as its write-1-to-clear keeps the flag set.
      status_d = (status_q & ~w1c) | edge_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q     <= RST_OUT[WIDTH-1:0];
         dir_q     <= RST_DIR[WIDTH-1:0];
         rise_en_q <= '0;
         fall_en_q <= '0;
         status_q  <= '0;
         sync_q    <= '0;
         prev_q    <= '0;
      end else begin
         out_q     <= out_d;
         dir_q     <= dir_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         status_q  <= status_d;
         sync_q    <= sync_d;
         prev_q    <= prev_d;
      end
   end

   always_comb begin
      din = (dir_q & out_q) | (~dir_q & sync_last);
      DO  = 8'hFF;
      case (AD)
         3'd0:    DO = widen(din);
         3'd1:    DO = widen(dir_q);
         3'd2:    DO = widen(out_q);
         3'd3:    DO = widen(out_q);
         3'd4:    DO = widen(rise_en_q);
         3'd5:    DO = widen(fall_en_q);
         3'd6:    DO = widen(status_q);
         default: DO = ID_VAL;
      endcase
      irq = |(status_q & (rise_en_q | fall_en_q));
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_pad
      assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
   end

endmodule
